mux_arb_nx1: RTL and testbench

//  Parametrised N-to-1 data multiplexer with a registered, handshaked output.

---
 rtl/mux_arb_nx1.sv | 111 +++++++++++
 tb/tb_mux_arb_nx1.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nx1.sv
// N-to-1 multiplexer with a one-entry registered, handshaked output.
// Channels are picked either by a fixed index or by round-robin over valid inputs.
module mux_arb_nx1 #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [N*WIDTH-1:0]   e,
   input  logic [N-1:0]         e_valid,
   output logic [N-1:0]         e_ready,
   output logic [WIDTH-1:0]     salMux,
   output logic                 sal_valid,
   input  logic                 sal_ready,
   output logic [SELW-1:0]      sal_canal
);

   logic [WIDTH-1:0] chanData [N];
   logic [WIDTH-1:0] dataQ, dataD;
   logic [SELW-1:0]  canalQ, canalD;
   logic [SELW-1:0]  ptrQ, ptrD;
   logic             validQ, validD;

   logic [SELW-1:0]  grantIdx;
   logic             grantValid;
   logic             loadOk;
   logic             transfer;
   logic [SELW:0]    probe;
   logic [SELW-1:0]  probeIdx;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         chanData[i] = e[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin scans ptr, ptr+1, ... wrapping at N; first valid channel wins.
   always_comb begin
      grantIdx   = '0;
      grantValid = 1'b0;
      probe      = '0;
      probeIdx   = '0;
      if (!mode) begin
         if ({1'b0, sel} < (SELW+1)'(N)) begin
            grantIdx   = sel;
            grantValid = e_valid[sel];
         end
      end else begin
         for (int k = N - 1; k >= 0; k--) begin
            probe = {1'b0, ptrQ} + (SELW+1)'(k);
            if (probe >= (SELW+1)'(N)) begin
               probe = probe - (SELW+1)'(N);
            end
            probeIdx = probe[SELW-1:0];
            if (e_valid[probeIdx]) begin
               grantIdx   = probeIdx;
               grantValid = 1'b1;
            end
         end
      end
   end

   assign loadOk   = !validQ || sal_ready;
   assign transfer = grantValid && loadOk && !rst;

   always_comb begin
      e_ready = '0;
      if (transfer) begin
         e_ready[grantIdx] = 1'b1;
      end
   end

   always_comb begin
      dataD  = dataQ;
      canalD = canalQ;
      validD = validQ;
      ptrD   = ptrQ;
      if (transfer) begin
         dataD  = chanData[grantIdx];
         canalD = grantIdx;
         validD = 1'b1;
         if (mode) begin
            ptrD = (grantIdx == SELW'(N - 1)) ? '0 : grantIdx + 1'b1;
         end
      end else if (validQ && sal_ready) begin
         validD = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dataQ  <= '0;
         canalQ <= '0;
         validQ <= 1'b0;
         ptrQ   <= '0;
      end else begin
         dataQ  <= dataD;
         canalQ <= canalD;
         validQ <= validD;
         ptrQ   <= ptrD;
      end
   end

   assign salMux    = dataQ;
   assign sal_valid = validQ;
   assign sal_canal = canalQ;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed testbench for mux_arb_nx1 (WIDTH=32, N=4): fixed select, round-robin,
// wrap-around, stall/release, drain and reset during stall.
module tb_mux_arb_nx1;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic                 clk;
   logic                 rst;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [N*WIDTH-1:0]   e;
   logic [N-1:0]         e_valid;
   logic [N-1:0]         e_ready;
   logic [WIDTH-1:0]     salMux;
   logic                 sal_valid;
   logic                 sal_ready;
   logic [SELW-1:0]      sal_canal;

   logic [WIDTH-1:0] d [N];
   int vecCount  = 0;
   int missCount = 0;

   mux_arb_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .e         (e),
      .e_valid   (e_valid),
      .e_ready   (e_ready),
      .salMux    (salMux),
      .sal_valid (sal_valid),
      .sal_ready (sal_ready),
      .sal_canal (sal_canal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      mode      = 1'b0;
      sel       = 2'd0;
      e_valid   = 4'b1111;
      sal_ready = 1'b1;
      @(posedge clk);
      cycle();
      vecCount++;
      if (sal_valid !== 1'b0) begin
         missCount++;
         $display("[TB] FAIL reset_valid got=%b exp=0", sal_valid);
      end
      vecCount++;
      if (salMux !== 32'd0) begin
         missCount++;
         $display("[TB] FAIL reset_data got=%0d exp=0", salMux);
      end
      vecCount++;
      if (sal_canal !== 2'd0) begin
         missCount++;
         $display("[TB] FAIL reset_canal got=%0d exp=0", sal_canal);
      end
      vecCount++;
      if (e_ready !== 4'b0000) begin
         missCount++;
         $display("[TB] FAIL reset_eready got=%b exp=0000", e_ready);
      end
   endtask

   task automatic test_fixed();
      rst  = 1'b0;
      mode = 1'b0;
      sel  = 2'd2;
      #1;
      vecCount++;
      if (e_ready !== 4'b0100) begin
         missCount++;
         $display("[TB] FAIL fixed_eready got=%b exp=0100", e_ready);
      end
      cycle();
      vecCount++;
      if (salMux !== 32'd15 || sal_canal !== 2'd2 || sal_valid !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL fixed_sel2 got=%0d/%0d/%b exp=15/2/1", salMux, sal_canal, sal_valid);
      end
      sel = 2'd1;
      #1;
      vecCount++;
      if (e_ready !== 4'b0010) begin
         missCount++;
         $display("[TB] FAIL fixed_eready_sel1 got=%b exp=0010", e_ready);
      end
      cycle();
      vecCount++;
      if (salMux !== 32'd999 || sal_canal !== 2'd1 || sal_valid !== 1'b1) begin
         missCount++;
         $display("[TB] FAIL fixed_sel1 got=%0d/%0d/%b exp=999/1/1", salMux, sal_canal, sal_valid);
      end
   endtask

   // Round-robin pointer starts at 0 since fixed mode leaves it untouched.
   task automatic test_round_robin();
      logic [SELW-1:0] expCh [6];
      expCh = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      mode    = 1'b1;
      e_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         cycle();
         vecCount++;
         if (sal_canal !== expCh[i] || salMux !== d[expCh[i]] || sal_valid !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL rr_step%0d got=%0d/%h exp=%0d/%h", i, sal_canal, salMux,
                     expCh[i], d[expCh[i]]);
         end
      end
   endtask

   task automatic test_wrap();
      e_valid = 4'b1010;
      #1;
      vecCount++;
      if (e_ready !== 4'b1000) begin
         missCount++;
         $display("[TB] FAIL wrap_eready_first got=%b exp=1000", e_ready);
      end
      cycle();
      vecCount++;
      if (sal_canal !== 2'd3 || salMux !== d[3]) begin
         missCount++;
         $display("[TB] FAIL wrap_first got=%0d/%h exp=3/%h", sal_canal, salMux, d[3]);
      end
      vecCount++;
      if (e_ready !== 4'b0010) begin
         missCount++;
         $display("[TB] FAIL wrap_eready_second got=%b exp=0010", e_ready);
      end
      cycle();
      vecCount++;
      if (sal_canal !== 2'd1 || salMux !== d[1]) begin
         missCount++;
         $display("[TB] FAIL wrap_second got=%0d/%h exp=1/%h", sal_canal, salMux, d[1]);
      end
   endtask

   // Holding channel 1's word with ptr=2 on entry.
   task automatic test_stall();
      e_valid   = 4'b1111;
      sal_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         vecCount++;
         if (e_ready !== 4'b0000 || salMux !== d[1] || sal_canal !== 2'd1 || sal_valid !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL stall_cyc%0d got=%b/%h/%0d/%b exp=0000/%h/1/1", i, e_ready,
                     salMux, sal_canal, sal_valid, d[1]);
         end
         cycle();
      end
      sal_ready = 1'b1;
      #1;
      vecCount++;
      if (e_ready !== 4'b0100) begin
         missCount++;
         $display("[TB] FAIL release_eready got=%b exp=0100", e_ready);
      end
      cycle();
      vecCount++;
      if (sal_valid !== 1'b1 || sal_canal !== 2'd2 || salMux !== d[2]) begin
         missCount++;
         $display("[TB] FAIL release_load got=%b/%0d/%h exp=1/2/%h", sal_valid, sal_canal,
                  salMux, d[2]);
      end
   endtask

   // Holding channel 2's word with ptr=3; a reset must bring the search back to ch0.
   task automatic test_reset_in_stall();
      sal_ready = 1'b0;
      cycle();
      rst = 1'b1;
      #1;
      vecCount++;
      if (e_ready !== 4'b0000) begin
         missCount++;
         $display("[TB] FAIL rststall_eready got=%b exp=0000", e_ready);
      end
      cycle();
      rst       = 1'b0;
      sal_ready = 1'b1;
      #1;
      vecCount++;
      if (sal_valid !== 1'b0 || salMux !== 32'd0 || sal_canal !== 2'd0) begin
         missCount++;
         $display("[TB] FAIL rststall_clear got=%b/%h/%0d exp=0/0/0", sal_valid, salMux, sal_canal);
      end
      vecCount++;
      if (e_ready !== 4'b0001) begin
         missCount++;
         $display("[TB] FAIL rststall_ptr got=%b exp=0001", e_ready);
      end
      cycle();
      vecCount++;
      if (sal_valid !== 1'b1 || sal_canal !== 2'd0 || salMux !== d[0]) begin
         missCount++;
         $display("[TB] FAIL rststall_resume got=%b/%0d/%h exp=1/0/%h", sal_valid, sal_canal,
                  salMux, d[0]);
      end
   endtask

   task automatic test_drain();
      e_valid   = 4'b0000;
      sal_ready = 1'b1;
      #1;
      vecCount++;
      if (e_ready !== 4'b0000) begin
         missCount++;
         $display("[TB] FAIL drain_eready got=%b exp=0000", e_ready);
      end
      cycle();
      vecCount++;
      if (sal_valid !== 1'b0 || salMux !== d[0] || sal_canal !== 2'd0) begin
         missCount++;
         $display("[TB] FAIL drain_hold got=%b/%h/%0d exp=0/%h/0", sal_valid, salMux, sal_canal, d[0]);
      end
   endtask

   initial begin
      d[0] = 32'hA0A0_0001;
      d[1] = 32'd999;
      d[2] = 32'd15;
      d[3] = 32'hDEAD_BEEF;
      e    = {d[3], d[2], d[1], d[0]};
      rst       = 1'b1;
      mode      = 1'b0;
      sel       = 2'd0;
      e_valid   = 4'b0000;
      sal_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_fixed();
      test_round_robin();
      test_wrap();
      test_stall();
      test_reset_in_stall();
      test_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
